// File: rtl/axis_frame_accumulator.sv
// axis_frame_accumulator
//   Sums unsigned WIDTH-bit AXI-Stream beats into frames. A frame closes after
//   N beats or on a beat carrying s_last, whichever comes first. One output
//   beat per frame carries the binary sum, the beat count and, when the
//   BCD_OUT_EN macro is defined, a DIGITS-digit BCD copy of the sum. The BCD
//   copy saturates to all nines when the sum does not fit, with m_ovf set.
//   With BCD_OUT_EN undefined there is no converter and m_bcd/m_ovf are tied
//   to zero.
//
// Ports
//   clk      clock, all logic on posedge
//   rstn     asynchronous active-low reset
//   s_valid  input beat valid
//   s_ready  input beat ready (high while accumulating)
//   s_data   input sample, WIDTH bits unsigned
//   s_last   closes the frame early, this beat included
//   m_valid  output beat valid
//   m_ready  output beat ready
//   m_data   binary frame sum, SUM_W bits
//   m_count  beats in frame, 1..N
//   m_bcd    BCD frame sum, digit 0 in [3:0]
//   m_ovf    sum exceeds 10^DIGITS-1 (m_bcd saturated)
module axis_frame_accumulator #(
   parameter int unsigned  WIDTH  = 3,
   parameter int unsigned  N      = 10,
   parameter int unsigned  DIGITS = 2,
   localparam int unsigned SUM_W  = ((WIDTH + $clog2(N)) > (WIDTH + 1)) ?
                                    (WIDTH + $clog2(N)) : (WIDTH + 1),
   localparam int unsigned CNT_W  = $clog2(N + 1)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [SUM_W-1:0]      m_data,
   output logic [CNT_W-1:0]      m_count,
   output logic [4*DIGITS-1:0]   m_bcd,
   output logic                  m_ovf
);

`ifdef BCD_OUT_EN
   localparam logic [1:0] ST_ACC  = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;
`else
   localparam logic [1:0] ST_ACC  = 2'd0;
   localparam logic [1:0] ST_OUT  = 2'd2;
`endif

   logic [1:0]       state;
   logic [SUM_W-1:0] acc;
   logic [SUM_W-1:0] sum_next;
   logic [CNT_W-1:0] cnt;
   logic             take;
   logic             close;
   logic             conv_done;

   // Ready and valid decode straight from the registered state, so m_ready
   // never reaches s_ready combinationally.
   assign s_ready  = (state == ST_ACC);
   assign m_valid  = (state == ST_OUT);
   assign take     = s_valid && s_ready;
   assign sum_next = acc + SUM_W'(s_data);
   // An s_last on the N-th beat is the same close event, not a second one.
   assign close    = take && ((cnt == CNT_W'(N - 1)) || s_last);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_ACC;
         acc     <= '0;
         cnt     <= '0;
         m_data  <= '0;
         m_count <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               if (take) begin
                  acc <= sum_next;
                  cnt <= cnt + CNT_W'(1);
                  if (close) begin
                     m_data  <= sum_next;
                     m_count <= cnt + CNT_W'(1);
`ifdef BCD_OUT_EN
                     state   <= ST_CONV;
`else
                     state   <= ST_OUT;
`endif
                  end
               end
            end
`ifdef BCD_OUT_EN
            ST_CONV: begin
               if (conv_done) state <= ST_OUT;
            end
`endif
            ST_OUT: begin
               if (m_ready) begin
                  state <= ST_ACC;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

`ifdef BCD_OUT_EN
   function automatic logic [63:0] pow10(input int unsigned d);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam int unsigned CONV_W  = $clog2(SUM_W + 1);
   localparam logic [63:0] BCD_MAX = pow10(DIGITS) - 64'd1;

   logic [SUM_W-1:0]          bin_sh;
   logic [4*DIGITS-1:0]       bcd_sh;
   logic [4*DIGITS-1:0]       bcd_adj;
   logic [4*DIGITS-1:0]       nines;
   logic [4*DIGITS+SUM_W-1:0] dd_sh;
   logic [CONV_W-1:0]         conv_cnt;
   logic                      ovf;

   // Double-dabble step: add 3 to every digit >= 5, then shift the joint
   // BCD:binary register left by one. The BCD field is only DIGITS wide;
   // bits lost off its top only matter when the sum overflows, and that
   // case is replaced by all nines.
   always_comb begin
      bcd_adj = bcd_sh;
      nines   = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
         nines[4*i +: 4] = 4'd9;
      end
   end

   assign dd_sh     = {bcd_adj, bin_sh} << 1;
   assign conv_done = (state == ST_CONV) && (conv_cnt == CONV_W'(SUM_W - 1));
   assign ovf       = (64'(m_data) > BCD_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bin_sh   <= '0;
         bcd_sh   <= '0;
         conv_cnt <= '0;
         m_bcd    <= '0;
         m_ovf    <= 1'b0;
      end else if (close) begin
         bin_sh   <= sum_next;
         bcd_sh   <= '0;
         conv_cnt <= '0;
      end else if (state == ST_CONV) begin
         bin_sh   <= dd_sh[SUM_W-1:0];
         bcd_sh   <= dd_sh[4*DIGITS+SUM_W-1:SUM_W];
         conv_cnt <= conv_cnt + CONV_W'(1);
         if (conv_done) begin
            m_bcd <= ovf ? nines : dd_sh[4*DIGITS+SUM_W-1:SUM_W];
            m_ovf <= ovf;
         end
      end
   end
`else
   assign conv_done = 1'b0;
   assign m_bcd     = '0;
   assign m_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_accumulator.sv
// tb_axis_frame_accumulator
//   Scoreboard bench for axis_frame_accumulator. The driver issues beats; an
//   input monitor forms frames from accepted beats using the frame rules
//   (N beats or s_last) and queues the expected output beat; an output
//   monitor compares every cycle m_valid is high against the queue head and
//   pops on the handshake. A second instance with DIGITS=1 covers BCD
//   saturation. Honours BCD_OUT_EN for latency and BCD expectations.
module tb_axis_frame_accumulator;

   localparam int W   = 3;
   localparam int N   = 10;
   localparam int D   = 2;
   localparam int SW  = 7;
   localparam int CW  = 4;
`ifdef BCD_OUT_EN
   localparam int LAT = SW;
`else
   localparam int LAT = 0;
`endif

   typedef struct packed {
      logic [31:0] sum;
      logic [31:0] cnt;
      logic [15:0] bcd;
      logic        ovf;
   } exp_t;

   logic            clk;
   logic            rstn;
   logic            s_valid, s_ready, s_last, m_valid, m_ready, m_ovf;
   logic [W-1:0]    s_data;
   logic [SW-1:0]   m_data;
   logic [CW-1:0]   m_count;
   logic [4*D-1:0]  m_bcd;

   logic            s_valid1, s_ready1, s_last1, m_valid1, m_ready1, m_ovf1;
   logic [W-1:0]    s_data1;
   logic [SW-1:0]   m_data1;
   logic [CW-1:0]   m_count1;
   logic [3:0]      m_bcd1;

   int   checks, failures, timeouts, cyc, exp_rise;
   int   psum, pcnt, psum1, pcnt1;
   bit   in_flight, mv_prev, done, rdy_rand;
   exp_t exp_q[$];
   exp_t exp1_q[$];
   exp_t e, e1;

   axis_frame_accumulator #(.WIDTH(W), .N(N), .DIGITS(D)) u_dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
      .m_bcd(m_bcd), .m_ovf(m_ovf)
   );

   axis_frame_accumulator #(.WIDTH(W), .N(N), .DIGITS(1)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_last(s_last1),
      .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_count(m_count1),
      .m_bcd(m_bcd1), .m_ovf(m_ovf1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a frame sum rendered as decimal digits, or all nines if too big.
   function automatic exp_t make_exp(input int sum, input int cnt, input int digits);
      exp_t r;
      int   v;
      r.sum = 32'(sum);
      r.cnt = 32'(cnt);
      r.bcd = '0;
      r.ovf = 1'b0;
`ifdef BCD_OUT_EN
      if (sum > (10 ** digits) - 1) begin
         r.ovf = 1'b1;
         for (int d = 0; d < digits; d++) r.bcd[4*d +: 4] = 4'd9;
      end else begin
         v = sum;
         for (int d = 0; d < digits; d++) begin
            r.bcd[4*d +: 4] = 4'(v % 10);
            v = v / 10;
         end
      end
`else
      v = digits;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitors: everything is sampled on the falling edge, half a cycle away
   // from the rising edge where transfers happen.
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_s_ready", s_ready, 1);
         chk("rst_m_data", m_data, 0);
         chk("rst_m_count", m_count, 0);
         chk("rst_m_bcd", m_bcd, 0);
         chk("rst_m_ovf", m_ovf, 0);
         psum = 0; pcnt = 0; psum1 = 0; pcnt1 = 0;
         in_flight = 0; mv_prev = 0;
         exp_q.delete();
         exp1_q.delete();
      end else begin
         chk("s_ready", s_ready, !in_flight);
         if (m_valid) begin
            if (exp_q.size() == 0) chk("unexpected_m_valid", 1, 0);
            else begin
               e = exp_q[0];
               if (!mv_prev) chk("latency", cyc, exp_rise);
               chk("m_data", m_data, e.sum);
               chk("m_count", m_count, e.cnt);
               chk("m_bcd", m_bcd, e.bcd[7:0]);
               chk("m_ovf", m_ovf, e.ovf);
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  in_flight = 0;
               end
            end
         end
         mv_prev = m_valid;
         if (s_valid && s_ready) begin
            psum += int'(s_data);
            pcnt++;
            if (pcnt == N || s_last) begin
               exp_q.push_back(make_exp(psum, pcnt, D));
               in_flight = 1;
               exp_rise  = cyc + 1 + LAT;
               psum = 0; pcnt = 0;
            end
         end
         if (m_valid1) begin
            if (exp1_q.size() == 0) chk("u1_unexpected_m_valid", 1, 0);
            else begin
               e1 = exp1_q[0];
               chk("u1_m_data", m_data1, e1.sum);
               chk("u1_m_count", m_count1, e1.cnt);
               chk("u1_m_bcd", m_bcd1, e1.bcd[3:0]);
               chk("u1_m_ovf", m_ovf1, e1.ovf);
               if (m_ready1) void'(exp1_q.pop_front());
            end
         end
         if (s_valid1 && s_ready1) begin
            psum1 += int'(s_data1);
            pcnt1++;
            if (pcnt1 == N || s_last1) begin
               exp1_q.push_back(make_exp(psum1, pcnt1, 1));
               psum1 = 0; pcnt1 = 0;
            end
         end
      end
      if (done) begin
         chk("driver_timeouts", timeouts, 0);
         chk("pending_frames", exp_q.size(), 0);
         chk("u1_pending_frames", exp1_q.size(), 0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_beat(input int d, input bit last);
      int unsigned n;
      bit          took;
      n = 0; took = 0;
      s_valid = 1'b1; s_data = W'(d); s_last = last;
      while (!took && n < 300) begin
         @(negedge clk);
         took = s_ready;
         step();
         n++;
      end
      if (!took) timeouts++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b0;
         s_data  = W'($urandom);
         s_last  = 1'($urandom);
         step();
      end
   endtask

   task automatic send1(input int d, input bit last);
      int unsigned n;
      bit          took;
      n = 0; took = 0;
      s_valid1 = 1'b1; s_data1 = W'(d); s_last1 = last;
      while (!took && n < 300) begin
         @(negedge clk);
         took = s_ready1;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) timeouts++;
   endtask

   initial begin
      int n;
      checks = 0; failures = 0; timeouts = 0; cyc = 0; exp_rise = 0;
      done = 0; rdy_rand = 0;
      rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      s_valid1 = 1'b0; s_data1 = '0; s_last1 = 1'b0; m_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Full frame of ten 7s -> 70.
      for (int i = 0; i < 10; i++) send_beat(7, 1'b0);
      idle(15);
      // s_last on the N-th beat closes exactly one frame.
      for (int i = 0; i < 9; i++) send_beat(3, 1'b0);
      send_beat(3, 1'b1);
      idle(15);
      // 1,2,3 with s_last -> 6; next beat with s_last is a one-beat frame.
      send_beat(1, 1'b0); send_beat(2, 1'b0); send_beat(3, 1'b1);
      send_beat(4, 1'b1);
      idle(15);
      // Output held by m_ready=0; monitor checks stability and s_ready=0.
      m_ready = 1'b0;
      send_beat(2, 1'b0); send_beat(5, 1'b1);
      s_valid = 1'b0;
      n = 0;
      while (!m_valid && n < 100) begin step(); n++; end
      if (!m_valid) timeouts++;
      repeat (5) step();
      m_ready = 1'b1;
      idle(3);
      // Reset after 4 beats of 5 discards them; next ten 1s give 10.
      for (int i = 0; i < 4; i++) send_beat(5, 1'b0);
      s_valid = 1'b0;
      rstn = 1'b0; step(); step(); rstn = 1'b1;
      for (int i = 0; i < 10; i++) send_beat(1, 1'b0);
      idle(15);
      // Reset with a closed frame still pending: no output beat.
      m_ready = 1'b0;
      send_beat(6, 1'b1);
      s_valid = 1'b0;
      idle(3);
      rstn = 1'b0; step(); rstn = 1'b1;
      m_ready = 1'b1;
      idle(3);
      // Back-to-back frames, s_valid held high, m_ready high.
      for (int i = 0; i < 60; i++) send_beat($urandom_range(0, 7), $urandom_range(0, 3) == 0);
      // Random data, gaps, s_last and m_ready, with one mid-frame reset.
      rdy_rand = 1;
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
         send_beat($urandom_range(0, 7), $urandom_range(0, 5) == 0);
         if (i == 120) begin
            s_valid = 1'b0;
            rstn = 1'b0; step(); step(); rstn = 1'b1;
         end
      end
      rdy_rand = 0;
      m_ready  = 1'b1;
      idle(1);
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin idle(1); n++; end

      // DIGITS=1 instance: 7+7 = 14 saturates the single BCD digit.
      send1(7, 1'b0);
      send1(7, 1'b1);
      s_valid1 = 1'b0;
      n = 0;
      while (exp1_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      idle(2);
      done = 1;
      repeat (3) @(posedge clk);
   end

endmodule
